// File: rtl/raybox_pkg.sv
// Shared raybox definitions: video timing defaults, overlay colours (BBGGRR),
// minimap fetch FSM state encodings and the wall palette.
package raybox_pkg;

    localparam int RB_H_VIEW  = 640;
    localparam int RB_H_TOTAL = 800;
    localparam int RB_V_TOTAL = 525;

    typedef logic [1:0] wall_id_t;

    localparam logic [0:0] MOF_IDLE  = 1'b0;
    localparam logic [0:0] MOF_FETCH = 1'b1;

    localparam logic [5:0] RGB_OFF         = 6'b00_00_00;
    localparam logic [5:0] RGB_WALL0       = 6'b00_00_00;
    localparam logic [5:0] RGB_WALL1       = 6'b11_10_00;
    localparam logic [5:0] RGB_WALL2       = 6'b11_00_00;
    localparam logic [5:0] RGB_WALL3       = 6'b11_00_10;
    localparam logic [5:0] RGB_NO_ROW      = 6'b11_00_11;
    localparam logic [5:0] RGB_PLAYER_PIX  = 6'b00_11_11;
    localparam logic [5:0] RGB_PLAYER_CELL = 6'b00_01_00;
    localparam logic [5:0] RGB_GRID        = 6'b01_00_00;
    localparam logic [5:0] RGB_OTHER_CELL  = 6'b00_00_11;
    localparam logic [5:0] RGB_MAPDX_BAR   = 6'b00_00_10;
    localparam logic [5:0] RGB_MAPDY_BAR   = 6'b00_00_01;

    function automatic logic [5:0] wall_rgb(input wall_id_t id);
        logic [5:0] rgb;
        case (id)
            2'd1:    rgb = RGB_WALL1;
            2'd2:    rgb = RGB_WALL2;
            2'd3:    rgb = RGB_WALL3;
            default: rgb = RGB_WALL0;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/fixed_point_params.sv
// Shared fixed-point format for raybox datapaths: signed Q12.12, integer bits
// [Qm-1:0] and fraction bits [-1:-Qn].
`ifndef FIXED_POINT_PARAMS_SV
`define FIXED_POINT_PARAMS_SV
`define Qm 12
`define Qn 12
`define F signed [`Qm-1:-`Qn]
`endif

// File: rtl/map_row_buffer.sv
// One map row of wall IDs: single registered write port, combinational read
// port so the display path sees stored cells with no latency.
module map_row_buffer
    import raybox_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  wall_id_t          wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output wall_id_t          rdata_o
);

    wall_id_t mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/map_overlay_fetch.sv
// Minimap overlay: prefetches the next line's map row into a line buffer during
// horizontal blanking, then colours overlay pixels straight from registers.
module map_overlay_fetch
    import raybox_pkg::*;
#(
    parameter int MAP_WBITS = 4,
    parameter int MAP_HBITS = 4,
    parameter int MAP_SCALE = 3,
    parameter int OVL_X     = 0,
    parameter int OVL_Y     = 0,
    parameter int H_VIEW    = RB_H_VIEW,
    parameter int H_TOTAL   = RB_H_TOTAL,
    parameter int V_TOTAL   = RB_V_TOTAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           hpos,
    input  logic [9:0]           vpos,
    input  logic `F              playerX,
    input  logic `F              playerY,
    input  logic [5:0]           i_otherx,
    input  logic [5:0]           i_othery,
    input  logic [5:0]           i_mapdx,
    input  logic [5:0]           i_mapdy,
    output logic                 o_map_req,
    output logic [MAP_WBITS-1:0] o_map_col,
    output logic [MAP_HBITS-1:0] o_map_row,
    input  logic                 i_map_gnt,
    input  wall_id_t             i_map_val,
    output logic                 in_map_overlay,
    output logic [5:0]           map_rgb,
    output logic                 o_fetch_miss,
    output logic [0:0]           o_dbg_state
);

    localparam int XW = MAP_WBITS + MAP_SCALE;
    localparam int YW = MAP_HBITS + MAP_SCALE;
    localparam logic [10:0] X_LO = 11'(OVL_X);
    localparam logic [10:0] X_HI = 11'(OVL_X + (1 << XW) + 1);
    localparam logic [10:0] Y_LO = 11'(OVL_Y);
    localparam logic [10:0] Y_HI = 11'(OVL_Y + (1 << YW) + 1);
    localparam logic [9:0]  H_START = 10'(H_VIEW);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [MAP_WBITS-1:0] COL_LAST = '1;

    logic [0:0]           state_q, state_d;
    logic [MAP_WBITS-1:0] col_q, col_d;
    logic [MAP_HBITS-1:0] row_q, row_d;
    logic                 valid_q, valid_d;
    logic                 miss_q, miss_d;
    logic                 buf_we;

    logic [9:0]     next_line, rel_nl, rel_h, rel_v;
    logic           next_in_ovl, h_in, v_in;
    logic [MAP_WBITS:0] cell_x;
    logic [MAP_HBITS:0] cell_y;
    logic           player_pix, player_cell, gridline, other_cell, dx_bar, dy_bar;
    wall_id_t       cell_id;
    logic           unused_bits;

    assign next_line   = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    assign rel_nl      = next_line - 10'(OVL_Y);
    assign next_in_ovl = ({1'b0, next_line} >= Y_LO) && ({1'b0, next_line} < Y_HI);

    // Request/grant: o_map_req stays high for the whole FETCH state; a grant
    // seen in FETCH means i_map_val is the cell at o_map_col/o_map_row now.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        miss_d  = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            MOF_IDLE: begin
                if (hpos == H_START && next_in_ovl) begin
                    state_d = MOF_FETCH;
                    col_d   = '0;
                    row_d   = rel_nl[YW-1:MAP_SCALE];
                end
            end
            default: begin
                if (hpos == H_LAST) begin
                    state_d = MOF_IDLE;
                    valid_d = 1'b0;
                    miss_d  = 1'b1;
                end else if (i_map_gnt) begin
                    buf_we = 1'b1;
                    if (col_q == COL_LAST) begin
                        valid_d = 1'b1;
                        state_d = MOF_IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MOF_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
        end
    end

    assign o_map_req    = (state_q == MOF_FETCH);
    assign o_map_col    = col_q;
    assign o_map_row    = row_q;
    assign o_fetch_miss = miss_q;
    assign o_dbg_state  = state_q;

    map_row_buffer #(.ADDR_W(MAP_WBITS)) u_row_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .waddr_i (col_q),
        .wdata_i (i_map_val),
        .raddr_i (cell_x[MAP_WBITS-1:0]),
        .rdata_o (cell_id)
    );

    assign rel_h = hpos - 10'(OVL_X);
    assign rel_v = vpos - 10'(OVL_Y);
    assign h_in  = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI);
    assign v_in  = ({1'b0, vpos} >= Y_LO) && ({1'b0, vpos} < Y_HI);
    assign in_map_overlay = h_in && v_in;

    // One extra bit on the cell index covers the closing gridline column/row.
    assign cell_x = rel_h[XW:MAP_SCALE];
    assign cell_y = rel_v[YW:MAP_SCALE];

    assign player_pix  = (rel_h[XW:0] == {1'b0, playerX[MAP_WBITS-1:-MAP_SCALE]})
                      && (rel_v[YW:0] == {1'b0, playerY[MAP_HBITS-1:-MAP_SCALE]});
    assign player_cell = (cell_x == {1'b0, playerX[MAP_WBITS-1:0]})
                      && (cell_y == {1'b0, playerY[MAP_HBITS-1:0]});
    assign gridline    = (rel_h[MAP_SCALE-1:0] == '0) || (rel_v[MAP_SCALE-1:0] == '0);
    assign other_cell  = (6'(cell_x) == i_otherx) && (6'(cell_y) == i_othery);
    assign dx_bar      = (i_mapdx != 6'd0) && (6'(cell_x) == i_mapdx);
    assign dy_bar      = (i_mapdy != 6'd0) && (6'(cell_y) == i_mapdy);

    always_comb begin
        map_rgb = RGB_OFF;
        if (in_map_overlay) begin
            if (player_pix)       map_rgb = RGB_PLAYER_PIX;
            else if (player_cell) map_rgb = RGB_PLAYER_CELL;
            else if (gridline)    map_rgb = RGB_GRID;
            else if (other_cell)  map_rgb = RGB_OTHER_CELL;
            else if (dx_bar)      map_rgb = RGB_MAPDX_BAR;
            else if (dy_bar)      map_rgb = RGB_MAPDY_BAR;
            else if (valid_q)     map_rgb = wall_rgb(cell_id);
            else                  map_rgb = RGB_NO_ROW;
        end
    end

    assign unused_bits = ^{playerX, playerY, rel_h, rel_v, rel_nl};

endmodule
